mod16_async_down_counter: RTL and testbench

//  4-bit asynchronous (ripple) modulo-16 down counter built from four JK flip-flop stages.

---
 rtl/mod16_async_down_counter.sv | 60 ++++++
 tb/tb_mod16_async_down_counter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mod16_async_down_counter.sv
// Ripple modulo-2**WIDTH down counter: a chain of JK stages where each stage
// after the first is clocked by the rising edge of the previous stage's output.

module jk_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

module mod16_async_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             j,
  input  logic             k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  // A stage only advances when its predecessor rises (0->1), which is the
  // borrow condition of a down count.
  logic [WIDTH-1:0] stage_clk;

  assign stage_clk[0] = clk;

  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_clk
    assign stage_clk[gi] = q[gi-1];
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    jk_stage u_stage (
      .clk   (stage_clk[gi]),
      .rst_n (reset),
      .j     (j),
      .k     (k),
      .q     (q[gi])
    );
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_mod16_async_down_counter.sv
// Bench for the ripple down counter: directed scenarios followed by random
// j/k/reset stimulus, compared against an arithmetic model of the settled word.

module tb_mod16_async_down_counter;

  logic       clk = 1'b1;
  logic       reset;
  logic       j;
  logic       k;
  logic [3:0] q;
  logic [3:0] q_bar;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_q;

  mod16_async_down_counter #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .j     (j),
    .k     (k),
    .q     (q),
    .q_bar (q_bar)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Settled word after one clk edge, derived from the mode's effect on the count.
  function automatic logic [3:0] next_word(input logic [3:0] cur, input logic jj, input logic kk);
    logic [3:0] dec;
    dec = cur - 4'd1;
    case ({jj, kk})
      2'b11:   return dec;             // decrement with wrap
      2'b10:   return cur | dec;       // set ripples through trailing zeros
      2'b01:   return cur & 4'b1110;   // clearing q0 never clocks later stages
      default: return cur;
    endcase
  endfunction

  task automatic check_word(input string tag);
    check({tag, "_q"}, q, model_q);
    check({tag, "_qbar"}, q_bar, ~model_q);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (reset) model_q = next_word(model_q, j, k);
    check_word(tag);
  endtask

  task automatic set_in(input logic r, input logic jj, input logic kk, input string tag);
    @(negedge clk);
    reset = r;
    j     = jj;
    k     = kk;
    #1;
    if (!r) model_q = 4'b0000;
    check_word(tag);
  endtask

  initial begin
    reset   = 1'b0;
    j       = 1'b1;
    k       = 1'b1;
    model_q = 4'b0000;

    #1;
    check_word("rst_t0");
    for (int i = 0; i < 4; i++) tick("rst_hold");

    set_in(1'b1, 1'b1, 1'b1, "release");
    for (int i = 0; i < 17; i++) tick("count");
    check("wrap_const", q, 4'b1111);

    for (int i = 0; i < 5; i++) tick("count_to_a");
    check("at_1010", q, 4'b1010);
    set_in(1'b0, 1'b1, 1'b1, "async_clr");
    check("async_clr_const", q, 4'b0000);
    set_in(1'b1, 1'b1, 1'b1, "rerelease");
    tick("after_rerelease");
    check("rerelease_const", q, 4'b1111);

    for (int i = 0; i < 4; i++) tick("count_to_b");
    check("at_1011", q, 4'b1011);
    set_in(1'b1, 1'b0, 1'b0, "hold_mode");
    for (int i = 0; i < 5; i++) tick("hold");
    set_in(1'b1, 1'b1, 1'b1, "resume");
    tick("resume_edge");
    check("resume_const", q, 4'b1010);

    set_in(1'b0, 1'b1, 0, "pre_set");
    set_in(1'b1, 1'b1, 1'b0, "set_mode");
    tick("set_edge");
    check("set_const", q, 4'b1111);
    set_in(1'b1, 1'b0, 1'b1, "clr_mode");
    for (int i = 0; i < 3; i++) tick("clr_edge");
    check("clr_const", q, 4'b1110);

    // reset toggling every 100 ns while counting
    for (int i = 0; i < 8; i++) begin
      set_in(logic'(i % 2), 1'b1, 1'b1, "rst_toggle");
      tick("rst_toggle_edge");
    end

    for (int i = 0; i < 300; i++) begin
      logic r;
      r = ($urandom_range(0, 9) != 0);
      set_in(r, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), "rnd_in");
      tick("rnd_edge");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
